// File: rtl/cycle_enable_generator_pkg.sv
// ----------------------------------------------------------------------------
// clock_pkg
// Shared types and default ratios for the cycle enable generator.
//   video_mode_t : NTSC / PAL selection as carried by pal_mode / pal_active.
//   *_DEF        : default divisor, phi2 and counter-width constants.
//   div_ok()     : range check used by the elaboration-time parameter checks.
// ----------------------------------------------------------------------------
package clock_pkg;

    typedef enum logic {
        MODE_NTSC = 1'b0,
        MODE_PAL  = 1'b1
    } video_mode_t;

    localparam int unsigned CNT_W_DEF         = 5;
    localparam int unsigned NTSC_CPU_DIV_DEF  = 12;
    localparam int unsigned NTSC_PPU_DIV_DEF  = 4;
    localparam int unsigned PAL_CPU_DIV_DEF   = 16;
    localparam int unsigned PAL_PPU_DIV_DEF   = 5;
    localparam int unsigned NTSC_PHI2_LOW_DEF = 5;
    localparam int unsigned PAL_PHI2_LOW_DEF  = 7;
    localparam int unsigned PAD_DIV_DEF       = 43;
    localparam int unsigned PAD_W_DEF         = 6;

    // A divisor must be at least 2 and representable by a w-bit counter.
    function automatic bit div_ok(input int unsigned div, input int unsigned w);
        return (div >= 2) && (div <= (32'd1 << w));
    endfunction

endpackage

// File: rtl/cycle_enable_generator_if.sv
// ----------------------------------------------------------------------------
// cycle_enable_generator_if
// Control and enable bundle between the generator and its consumers.
//   pal_mode   : requested mode (0 NTSC, 1 PAL), driven by master
//   cpu_halt   : DMA stall, suppresses cpu_en, driven by master
//   cpu_en     : one-cycle pulse per CPU cycle
//   apu_en     : one-cycle pulse every second CPU-cycle boundary
//   ppu_en     : one-cycle pulse per PPU dot
//   phi2       : cartridge M2 level
//   pad_en     : one-cycle pulse every PAD_DIV base cycles
//   pal_active : mode currently in effect
// master = consumer side, slave = generator side.
// ----------------------------------------------------------------------------
interface cycle_enable_generator_if;

    logic pal_mode;
    logic cpu_halt;
    logic cpu_en;
    logic apu_en;
    logic ppu_en;
    logic phi2;
    logic pad_en;
    logic pal_active;

    modport master (
        output pal_mode,
        output cpu_halt,
        input  cpu_en,
        input  apu_en,
        input  ppu_en,
        input  phi2,
        input  pad_en,
        input  pal_active
    );

    modport slave (
        input  pal_mode,
        input  cpu_halt,
        output cpu_en,
        output apu_en,
        output ppu_en,
        output phi2,
        output pad_en,
        output pal_active
    );

endinterface

// File: rtl/cycle_enable_generator_counter.sv
// ----------------------------------------------------------------------------
// mod_counter
// Modulo counter: counts 0..modulus-1 and wraps to 0.
//   clk      : base clock
//   reset    : synchronous active-high reset, count -> 0
//   clear    : synchronous clear, count -> 0 on the next edge
//   modulus  : current modulus (2..2^W), may change at runtime
//   count    : current count
//   terminal : high while count == modulus-1
// ----------------------------------------------------------------------------
module mod_counter #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic [W:0]   modulus,
    output logic [W-1:0] count,
    output logic         terminal
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         term;

    always_comb begin
        term    = ({1'b0, count_q} == (modulus - (W+1)'(1)));
        count_d = (clear || term) ? '0 : count_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    assign terminal = term;

endmodule

// File: rtl/cycle_enable_generator.sv
// ----------------------------------------------------------------------------
// cycle_enable_generator
// Derives CPU/APU/PPU/pad enable pulses and the phi2 level from the single
// base clock, with runtime NTSC/PAL ratio selection and CPU halt.
//   clk   : base clock (21.47 MHz NTSC / 26.6 MHz PAL master)
//   reset : synchronous active-high reset; pal_active loads pal_mode
//   bus   : slave side of cycle_enable_generator_if
//           in : pal_mode, cpu_halt
//           out: cpu_en, apu_en, ppu_en, phi2, pad_en, pal_active
// All outputs are registered.
// ----------------------------------------------------------------------------
module cycle_enable_generator
    import clock_pkg::*;
#(
    parameter int unsigned CNT_W         = CNT_W_DEF,
    parameter int unsigned NTSC_CPU_DIV  = NTSC_CPU_DIV_DEF,
    parameter int unsigned NTSC_PPU_DIV  = NTSC_PPU_DIV_DEF,
    parameter int unsigned PAL_CPU_DIV   = PAL_CPU_DIV_DEF,
    parameter int unsigned PAL_PPU_DIV   = PAL_PPU_DIV_DEF,
    parameter int unsigned NTSC_PHI2_LOW = NTSC_PHI2_LOW_DEF,
    parameter int unsigned PAL_PHI2_LOW  = PAL_PHI2_LOW_DEF,
    parameter int unsigned PAD_DIV       = PAD_DIV_DEF,
    parameter int unsigned PAD_W         = PAD_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    cycle_enable_generator_if.slave bus
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (!div_ok(NTSC_CPU_DIV, CNT_W)) begin : g_bad_ntsc_cpu_div
        $error("NTSC_CPU_DIV out of range");
    end
    if (!div_ok(NTSC_PPU_DIV, CNT_W)) begin : g_bad_ntsc_ppu_div
        $error("NTSC_PPU_DIV out of range");
    end
    if (!div_ok(PAL_CPU_DIV, CNT_W)) begin : g_bad_pal_cpu_div
        $error("PAL_CPU_DIV out of range");
    end
    if (!div_ok(PAL_PPU_DIV, CNT_W)) begin : g_bad_pal_ppu_div
        $error("PAL_PPU_DIV out of range");
    end
    if (!div_ok(PAD_DIV, PAD_W)) begin : g_bad_pad_div
        $error("PAD_DIV out of range");
    end
    if ((NTSC_PHI2_LOW < 1) || (NTSC_PHI2_LOW > NTSC_CPU_DIV - 1)) begin : g_bad_ntsc_phi2
        $error("NTSC_PHI2_LOW out of range");
    end
    if ((PAL_PHI2_LOW < 1) || (PAL_PHI2_LOW > PAL_CPU_DIV - 1)) begin : g_bad_pal_phi2
        $error("PAL_PHI2_LOW out of range");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    video_mode_t pal_active_q, pal_active_d;
    logic        apu_phase_q, apu_phase_d;
    logic        cpu_en_q, cpu_en_d;
    logic        apu_en_q, apu_en_d;
    logic        ppu_en_q, ppu_en_d;
    logic        phi2_q, phi2_d;
    logic        pad_en_q, pad_en_d;

    logic [CNT_W:0]   cur_cpu_div;
    logic [CNT_W:0]   cur_ppu_div;
    logic [CNT_W:0]   cur_phi2_low;

    logic [CNT_W-1:0] cpu_cnt;
    logic [CNT_W-1:0] cpu_cnt_nxt;
    logic [CNT_W-1:0] ppu_cnt;
    logic [PAD_W-1:0] pad_cnt;
    logic             cpu_term;
    logic             ppu_term;
    logic             pad_term;
    logic             mode_switch;
    video_mode_t      req_mode;

    // Ratios follow the mode in effect, never the raw request.
    always_comb begin
        if (pal_active_q == MODE_PAL) begin
            cur_cpu_div  = (CNT_W+1)'(PAL_CPU_DIV);
            cur_ppu_div  = (CNT_W+1)'(PAL_PPU_DIV);
            cur_phi2_low = (CNT_W+1)'(PAL_PHI2_LOW);
        end else begin
            cur_cpu_div  = (CNT_W+1)'(NTSC_CPU_DIV);
            cur_ppu_div  = (CNT_W+1)'(NTSC_PPU_DIV);
            cur_phi2_low = (CNT_W+1)'(NTSC_PHI2_LOW);
        end
    end

    // A mode change only takes effect on a CPU boundary, so the last cycle
    // in the old mode and the first in the new one are both full length.
    assign req_mode    = video_mode_t'(bus.pal_mode);
    assign mode_switch = cpu_term && (req_mode != pal_active_q);

    mod_counter #(.W(CNT_W)) u_cpu_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (mode_switch),
        .modulus  (cur_cpu_div),
        .count    (cpu_cnt),
        .terminal (cpu_term)
    );

    mod_counter #(.W(CNT_W)) u_ppu_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (mode_switch),
        .modulus  (cur_ppu_div),
        .count    (ppu_cnt),
        .terminal (ppu_term)
    );

    // Pad timing is mode independent and never cleared by a switch.
    mod_counter #(.W(PAD_W)) u_pad_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (1'b0),
        .modulus  ((PAD_W+1)'(PAD_DIV)),
        .count    (pad_cnt),
        .terminal (pad_term)
    );

    // Only the terminal flags of the PPU and pad counters are consumed.
    logic unused_cnt;
    assign unused_cnt = ^{ppu_cnt, pad_cnt};

    always_comb begin
        // phi2 is registered from the count the CPU counter is about to hold,
        // so the level lines up with cpu_cnt in the following cycle.
        cpu_cnt_nxt  = cpu_term ? '0 : cpu_cnt + CNT_W'(1);
        phi2_d       = ({1'b0, cpu_cnt_nxt} >= cur_phi2_low);

        cpu_en_d     = cpu_term && !bus.cpu_halt;
        apu_en_d     = cpu_term && apu_phase_q;
        apu_phase_d  = apu_phase_q ^ cpu_term;
        ppu_en_d     = ppu_term;
        pad_en_d     = pad_term;
        pal_active_d = mode_switch ? req_mode : pal_active_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pal_active_q <= req_mode;
            apu_phase_q  <= 1'b0;
            cpu_en_q     <= 1'b0;
            apu_en_q     <= 1'b0;
            ppu_en_q     <= 1'b0;
            phi2_q       <= 1'b0;
            pad_en_q     <= 1'b0;
        end else begin
            pal_active_q <= pal_active_d;
            apu_phase_q  <= apu_phase_d;
            cpu_en_q     <= cpu_en_d;
            apu_en_q     <= apu_en_d;
            ppu_en_q     <= ppu_en_d;
            phi2_q       <= phi2_d;
            pad_en_q     <= pad_en_d;
        end
    end

    assign bus.cpu_en     = cpu_en_q;
    assign bus.apu_en     = apu_en_q;
    assign bus.ppu_en     = ppu_en_q;
    assign bus.phi2       = phi2_q;
    assign bus.pad_en     = pad_en_q;
    assign bus.pal_active = (pal_active_q == MODE_PAL);

endmodule

// File: tb/tb_cycle_enable_generator.sv
// ----------------------------------------------------------------------------
// tb_cycle_enable_generator
// Directed bench for cycle_enable_generator. Time t counts rising edges since
// reset was last released; expected outputs are written directly as
// functions of t for each scenario.
// ----------------------------------------------------------------------------
module tb_cycle_enable_generator;

    logic clk = 1'b0;
    logic reset;

    int n_assert = 0;
    int n_fail   = 0;

    cycle_enable_generator_if bus_if ();

    cycle_enable_generator #(
        .CNT_W         (5),
        .NTSC_CPU_DIV  (12),
        .NTSC_PPU_DIV  (4),
        .PAL_CPU_DIV   (16),
        .PAL_PPU_DIV   (5),
        .NTSC_PHI2_LOW (5),
        .PAL_PHI2_LOW  (7),
        .PAD_DIV       (43),
        .PAD_W         (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_cpu, input logic e_apu,
                           input logic e_ppu, input logic e_phi2, input logic e_pad,
                           input logic e_pal);
        chk({tag, " cpu_en"},     bus_if.cpu_en,     e_cpu);
        chk({tag, " apu_en"},     bus_if.apu_en,     e_apu);
        chk({tag, " ppu_en"},     bus_if.ppu_en,     e_ppu);
        chk({tag, " phi2"},       bus_if.phi2,       e_phi2);
        chk({tag, " pad_en"},     bus_if.pad_en,     e_pad);
        chk({tag, " pal_active"}, bus_if.pal_active, e_pal);
    endtask

    task automatic exp_ntsc(input string tag, input int t);
        chk_all($sformatf("%s t=%0d", tag, t),
                (t % 12) == 0, (t % 24) == 0, (t % 4) == 0,
                (t % 12) >= 5, (t % 43) == 0, 1'b0);
    endtask

    task automatic reset_dut(input logic mode);
        bus_if.pal_mode = mode;
        bus_if.cpu_halt = 1'b0;
        reset = 1'b1;
        step();
        step();
        chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mode);
        reset = 1'b0;
    endtask

    // NTSC -> PAL switch requested at cpu_cnt=3; optionally with cpu_halt
    // held across the switching boundary at t=12.
    task automatic run_switch(input logic with_halt);
        string tag;
        int    u;
        tag = with_halt ? "switch+halt" : "switch";
        reset_dut(1'b0);
        for (int t = 1; t <= 60; t++) begin
            step();
            if (t < 12) begin
                exp_ntsc(tag, t);
            end else if (t == 12) begin
                chk_all($sformatf("%s t=12", tag), !with_halt, 1'b0, 1'b1,
                        1'b0, 1'b0, 1'b1);
            end else begin
                u = t - 12;
                chk_all($sformatf("%s t=%0d", tag, t),
                        (u % 16) == 0, (u % 32) == 16, (u % 5) == 0,
                        (u % 16) >= 7, (t % 43) == 0, 1'b1);
            end
            if (t == 3)                 bus_if.pal_mode = 1'b1;
            if (with_halt && t == 5)    bus_if.cpu_halt = 1'b1;
            if (t == 12)                bus_if.cpu_halt = 1'b0;
        end
    endtask

    initial begin
        reset           = 1'b1;
        bus_if.pal_mode = 1'b0;
        bus_if.cpu_halt = 1'b0;

        // NTSC free-run; a pal_mode pulse that ends before a boundary is ignored.
        reset_dut(1'b0);
        for (int t = 1; t <= 48; t++) begin
            step();
            exp_ntsc("ntsc", t);
            if (t == 5) bus_if.pal_mode = 1'b1;
            if (t == 8) bus_if.pal_mode = 1'b0;
        end

        // PAL straight out of reset.
        reset_dut(1'b1);
        for (int t = 1; t <= 64; t++) begin
            step();
            chk_all($sformatf("pal t=%0d", t),
                    (t % 16) == 0, (t % 32) == 0, (t % 5) == 0,
                    (t % 16) >= 7, (t % 43) == 0, 1'b1);
        end

        // Mode switch mid-CPU-cycle, then the same with a coincident halt.
        run_switch(1'b0);
        run_switch(1'b1);

        // Halt covering the boundaries at t=24, 36, 48.
        reset_dut(1'b0);
        for (int t = 1; t <= 72; t++) begin
            step();
            chk_all($sformatf("halt t=%0d", t),
                    ((t % 12) == 0) && (t != 24) && (t != 36) && (t != 48),
                    (t % 24) == 0, (t % 4) == 0, (t % 12) >= 5,
                    (t % 43) == 0, 1'b0);
            if (t == 13) bus_if.cpu_halt = 1'b1;
            if (t == 50) bus_if.cpu_halt = 1'b0;
        end

        // Reset at cpu_cnt=7 while phi2 is high.
        reset_dut(1'b0);
        for (int t = 1; t <= 7; t++) begin
            step();
            exp_ntsc("pre-abort", t);
        end
        reset = 1'b1;
        step();
        chk_all("abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        for (int t = 1; t <= 24; t++) begin
            step();
            exp_ntsc("post-abort", t);
        end

        // Long run across two mode switches: pad_en cadence is untouched.
        reset_dut(1'b0);
        for (int t = 1; t <= 10000; t++) begin
            step();
            chk($sformatf("freerun pad_en t=%0d", t), bus_if.pad_en, (t % 43) == 0);
            if (t == 1000) bus_if.pal_mode = 1'b1;
            if (t == 3000) chk("freerun pal_active t=3000", bus_if.pal_active, 1'b1);
            if (t == 5000) bus_if.pal_mode = 1'b0;
        end
        chk("freerun pal_active end", bus_if.pal_active, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
